// File: rtl/solar_pkg.sv
// Shared constants, FSM state encoding and the ADC command word for the
// solar panel acquisition front end.
package solar_pkg;

  localparam logic CHAN_VOLT  = 1'b0;
  localparam logic CHAN_CURR  = 1'b1;
  localparam int   FRAME_BITS = 16;
  localparam int   CMD_BITS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } state_t;

  // start, single-ended, channel select, MSB-first, then don't-care zeros
  function automatic logic [FRAME_BITS-1:0] adc_cmd(input logic chan);
    return {2'b11, chan, 1'b1, {(FRAME_BITS-CMD_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/solar_spi_shifter.sv
// SPI engine for one ADC frame: setup gap, 16 SCLK periods of command out /
// data in, then a combinational done on the last cycle of the trailing gap.
module solar_spi_shifter
  import solar_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          chan,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic          done,
  output logic [DW-1:0] data
);

  localparam int DCW = $clog2(CLK_DIV);

  logic                  active;
  logic [DCW-1:0]        div_cnt;
  logic [5:0]            half_cnt;
  logic [FRAME_BITS-1:0] cmd_sr;
  logic [FRAME_BITS-1:0] cmd;
  logic                  half_end;

  assign cmd      = adc_cmd(chan);
  assign half_end = active && (div_cnt == DCW'(CLK_DIV-1));
  // half_cnt 0 is the setup gap, 1..32 the SCLK half periods
  assign done     = half_end && (half_cnt == 6'(2*FRAME_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      cmd_sr   <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      data     <= '0;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= cmd[FRAME_BITS-1];
      cmd_sr   <= {cmd[FRAME_BITS-2:0], 1'b0};
      data     <= '0;
    end else if (active) begin
      if (half_end) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 6'd1;
        if (half_cnt == 6'(2*FRAME_BITS)) begin
          active <= 1'b0;
        end else if (half_cnt[0]) begin
          sclk   <= 1'b0;
          mosi   <= cmd_sr[FRAME_BITS-1];
          cmd_sr <= {cmd_sr[FRAME_BITS-2:0], 1'b0};
        end else begin
          sclk <= 1'b1;
          // rising edges 1..CMD_BITS overlap the command and carry no data
          if (half_cnt >= 6'(2*CMD_BITS))
            data <= {data[DW-2:0], miso};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solar_adc_sampler.sv
// Periodic two-channel ADC acquisition: period counter, frame sequencing FSM,
// single-entry valid/ready output register and sticky overrun flag.
module solar_adc_sampler
  import solar_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DW            = 12
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          enable_i,
  input  logic          adc_miso_i,
  output logic          adc_sclk_o,
  output logic          adc_cs_n_o,
  output logic          adc_mosi_o,
  output logic          sample_valid_o,
  input  logic          sample_ready_i,
  output logic          sample_chan_o,
  output logic [DW-1:0] sample_data_o,
  output logic          overrun_o,
  input  logic          overrun_clr_i
);

  localparam int DCW = $clog2(CLK_DIV);
  localparam int PW  = $clog2(SAMPLE_PERIOD);

  state_t         state;
  logic [DCW-1:0] tmr;
  logic [PW-1:0]  per_cnt;
  logic           cur_chan;
  logic           tick, tmr_end, frame_done, start, start_chan, sh_done, ovr_set;
  logic [DW-1:0]  sh_data;

  assign tick       = enable_i && (per_cnt == PW'(SAMPLE_PERIOD-1));
  assign tmr_end    = tmr == DCW'(CLK_DIV-1);
  assign frame_done = (state == ST_CS_HOLD) && tmr_end;
  assign start      = (state == ST_WAIT && tick) ||
                      (frame_done && cur_chan == CHAN_VOLT && enable_i);
  assign start_chan = (state == ST_CS_HOLD) ? CHAN_CURR : CHAN_VOLT;
  assign ovr_set    = (frame_done && sample_valid_o && !sample_ready_i) ||
                      (tick && state != ST_WAIT);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)    per_cnt <= '0;
    else if (!enable_i) per_cnt <= '0;
    else if (tick)      per_cnt <= '0;
    else                per_cnt <= per_cnt + 1'b1;
  end

  // CS stays low across a back-to-back voltage/current pair
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      cur_chan   <= CHAN_VOLT;
      adc_cs_n_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (enable_i) state <= ST_WAIT;
        ST_WAIT: begin
          if (start) begin
            state      <= ST_CS_SETUP;
            cur_chan   <= start_chan;
            tmr        <= '0;
            adc_cs_n_o <= 1'b0;
          end else if (!enable_i) begin
            state <= ST_IDLE;
          end
        end
        ST_CS_SETUP: begin
          if (tmr_end) begin
            state <= ST_SHIFT;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_SHIFT: if (sh_done) state <= ST_CS_HOLD;
        ST_CS_HOLD: begin
          if (!tmr_end) begin
            tmr <= tmr + 1'b1;
          end else begin
            tmr <= '0;
            if (start) begin
              state    <= ST_CS_SETUP;
              cur_chan <= start_chan;
            end else begin
              adc_cs_n_o <= 1'b1;
              state      <= enable_i ? ST_WAIT : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sample_valid_o <= 1'b0;
      sample_chan_o  <= 1'b0;
      sample_data_o  <= '0;
      overrun_o      <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!(sample_valid_o && !sample_ready_i)) begin
          sample_valid_o <= 1'b1;
          sample_chan_o  <= cur_chan;
          sample_data_o  <= sh_data;
        end
      end else if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
      if (ovr_set)            overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

  solar_spi_shifter #(.CLK_DIV(CLK_DIV), .DW(DW)) u_shifter (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .start (start),
    .chan  (start_chan),
    .miso  (adc_miso_i),
    .sclk  (adc_sclk_o),
    .mosi  (adc_mosi_o),
    .done  (sh_done),
    .data  (sh_data)
  );

endmodule

// File: tb/tb_solar_adc_sampler.sv
// Directed bench: SPI ADC model answering per decoded channel, handshake
// monitor, and a second instance with a too-short sample period.
module tb_solar_adc_sampler;
  import solar_pkg::*;

  logic clk = 1'b0;
  logic rst_n, enable, ready, clr;
  logic miso = 1'b0;
  logic sclk, cs_n, mosi, valid, chan, ovr;
  logic [11:0] data;
  logic en2, ready2, clr2, miso2;
  logic sclk2, cs_n2, mosi2, valid2, chan2, ovr2;
  logic [11:0] data2;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  solar_adc_sampler dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(enable), .adc_miso_i(miso),
    .adc_sclk_o(sclk), .adc_cs_n_o(cs_n), .adc_mosi_o(mosi),
    .sample_valid_o(valid), .sample_ready_i(ready), .sample_chan_o(chan),
    .sample_data_o(data), .overrun_o(ovr), .overrun_clr_i(clr)
  );

  solar_adc_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .DW(12)) dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(en2), .adc_miso_i(miso2),
    .adc_sclk_o(sclk2), .adc_cs_n_o(cs_n2), .adc_mosi_o(mosi2),
    .sample_valid_o(valid2), .sample_ready_i(ready2), .sample_chan_o(chan2),
    .sample_data_o(data2), .overrun_o(ovr2), .overrun_clr_i(clr2)
  );

  // ADC model: decodes channel from command bit 3, shifts data on falling edges
  logic [11:0] v_word = 12'hA5C;
  logic [11:0] c_word = 12'h3F1;
  int          rc = 0;
  logic        chan_rx = 1'b0;
  logic [15:0] mosi_sr = '0;
  logic [15:0] mosi_frames[$];

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) rc = 0;
    else begin
      mosi_sr = {mosi_sr[14:0], mosi};
      rc++;
      if (rc == 3) chan_rx = mosi;
      if (rc == 16) begin
        mosi_frames.push_back(mosi_sr);
        rc = 0;
      end
    end
  end

  always @(negedge sclk) begin
    logic [11:0] w;
    w = chan_rx ? c_word : v_word;
    miso = (rc >= 4) ? w[15-rc] : 1'b0;
  end

  typedef struct {logic ch; logic [11:0] d; int cyc;} hs_t;
  hs_t  hs_q[$];
  int   cyc = 0, cs_fall_cyc = 0;
  logic cs_q = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (cs_q && !cs_n) cs_fall_cyc = cyc;
    cs_q = cs_n;
    if (rst_n && valid && ready) hs_q.push_back('{chan, data, cyc});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs_fall(input string tag);
    for (int i = 0; i < 1200 && cs_n; i++) step(1);
    check(tag, 32'(cs_n), 32'd0);
  endtask

  int n, nf;

  initial begin
    rst_n = 1'b1; enable = 0; ready = 0; clr = 0;
    en2 = 0; ready2 = 1; clr2 = 0; miso2 = 0;
    #2 rst_n = 1'b0;
    step(3);
    check("rst_cs_n",  32'(cs_n),  32'd1);
    check("rst_sclk",  32'(sclk),  32'd0);
    check("rst_mosi",  32'(mosi),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_chan",  32'(chan),  32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    rst_n = 1'b1;
    step(2);

    // basic pair with ready tied high
    enable = 1; ready = 1;
    wait_cs_fall("a_cs_fall");
    for (int i = 0; i < 400 && hs_q.size() < 2; i++) step(1);
    check("a_hs_cnt", 32'(hs_q.size()), 32'd2);
    if (hs_q.size() >= 2) begin
      check("a_hs0_chan", 32'(hs_q[0].ch), 32'd0);
      check("a_hs0_data", 32'(hs_q[0].d),  32'hA5C);
      check("a_hs1_chan", 32'(hs_q[1].ch), 32'd1);
      check("a_hs1_data", 32'(hs_q[1].d),  32'h3F1);
      check("a_ch0_lat",  32'(hs_q[0].cyc - cs_fall_cyc), 32'd136);
      check("a_ch1_lat",  32'(hs_q[1].cyc - hs_q[0].cyc), 32'd136);
    end
    check("a_frames", 32'(mosi_frames.size()), 32'd2);
    if (mosi_frames.size() >= 2) begin
      check("a_mosi0", 32'(mosi_frames[0]), 32'hD000);
      check("a_mosi1", 32'(mosi_frames[1]), 32'hF000);
    end
    step(2);
    check("a_cs_high", 32'(cs_n), 32'd1);
    check("a_ovr",     32'(ovr),  32'd0);

    // stalled consumer over two periods
    ready = 0;
    step(2000);
    check("b_valid", 32'(valid), 32'd1);
    check("b_chan",  32'(chan),  32'd0);
    check("b_data",  32'(data),  32'hA5C);
    check("b_ovr",   32'(ovr),   32'd1);
    check("b_hs",    32'(hs_q.size()), 32'd2);
    for (int i = 0; i < 400 && !cs_n; i++) step(1);
    clr = 1; step(1); clr = 0;
    check("b_ovr_clr", 32'(ovr), 32'd0);

    // ready rises in the completion cycle of the next ch0 frame
    v_word = 12'h123;
    wait_cs_fall("c_cs_fall");
    step(135);
    ready = 1;
    step(1);
    check("c_valid", 32'(valid), 32'd1);
    check("c_chan",  32'(chan),  32'd0);
    check("c_data",  32'(data),  32'h123);
    check("c_ovr",   32'(ovr),   32'd0);
    check("c_old_hs", 32'(hs_q[hs_q.size()-1].d), 32'hA5C);
    step(150);

    // enable dropped during the ch0 frame
    n = hs_q.size(); nf = mosi_frames.size();
    wait_cs_fall("d_cs_fall");
    step(50);
    enable = 0;
    step(100);
    check("d_hs",      32'(hs_q.size()), 32'(n + 1));
    check("d_hs_chan", 32'(hs_q[hs_q.size()-1].ch), 32'd0);
    step(200);
    check("d_hs_after", 32'(hs_q.size()), 32'(n + 1));
    check("d_frames",   32'(mosi_frames.size()), 32'(nf + 1));
    check("d_cs_high",  32'(cs_n), 32'd1);
    check("d_idle",     32'(dut.state), 32'(ST_IDLE));

    // reset in the middle of the ch1 shift with a sample held
    enable = 1; ready = 0;
    wait_cs_fall("e_cs_fall");
    step(177);
    for (int i = 0; i < 10 && !sclk; i++) step(1);
    check("e_pre_sclk",  32'(sclk),  32'd1);
    check("e_pre_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("e_cs_n",  32'(cs_n),  32'd1);
    check("e_sclk",  32'(sclk),  32'd0);
    check("e_valid", 32'(valid), 32'd0);
    check("e_data",  32'(data),  32'd0);
    step(3);
    rst_n = 1'b1; ready = 1; c_word = 12'h5A7;
    n = hs_q.size();
    for (int i = 0; i < 1500 && hs_q.size() < n + 2; i++) step(1);
    check("e_hs", 32'(hs_q.size()), 32'(n + 2));
    if (hs_q.size() >= n + 2) begin
      check("e_hs0", 32'({hs_q[n].ch, hs_q[n].d}),     32'h0123);
      check("e_hs1", 32'({hs_q[n+1].ch, hs_q[n+1].d}), 32'h15A7);
    end
    check("e_mosi1", 32'(mosi_frames[mosi_frames.size()-1]), 32'hF000);
    check("e_mosi0", 32'(mosi_frames[mosi_frames.size()-2]), 32'hD000);
    check("e_ovr",   32'(ovr), 32'd0);

    // period shorter than a pair: second tick lands mid-frame
    en2 = 1;
    step(150);
    check("f_ovr_early", 32'(ovr2), 32'd0);
    step(300);
    check("f_ovr_set",   32'(ovr2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
